// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequences one decoded system instruction (CSRRW/S/C, ECALL, MRET)
// into read-modify-write or trap/return strobes on the machine-mode CSR file bus.
// Optional build macro: CSR_TRAP_ILLEGAL_EN (traps undefined ops and CSRRx to
// unimplemented addresses with mcause=2 instead of a no-op / normal access).
module csr_trap_ctrl #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic            req_use_imm,
  input  logic [4:0]      req_zimm,
  input  logic            req_src_zero,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [11:0]     req_csr_addr,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rd_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [3:0]      csr_ctl,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] mcause_value,
  output logic [XLEN-1:0] write_csr_data,
  input  logic [XLEN-1:0] read_csr_data
);

  localparam logic [2:0] OP_CSRRW = 3'b000;
  localparam logic [2:0] OP_CSRRS = 3'b001;
  localparam logic [2:0] OP_CSRRC = 3'b010;
  localparam logic [2:0] OP_ECALL = 3'b011;
  localparam logic [2:0] OP_MRET  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_TRAP,
    S_RET,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            use_imm_q, use_imm_d;
  logic [4:0]      zimm_q, zimm_d;
  logic            src_zero_q, src_zero_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [XLEN-1:0] new_q, new_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic            redir_vld_q, redir_vld_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] opnd;
  logic            addr_ok;

  // Operand select for the read-modify-write, from the latched request.
  always_comb begin
    opnd = use_imm_q ? {{(XLEN-5){1'b0}}, zimm_q} : rs1_q;
  end

  // Implemented-address check used only when illegal trapping is built in.
  always_comb begin
`ifdef CSR_TRAP_ILLEGAL_EN
    addr_ok = (req_csr_addr == 12'h300) || (req_csr_addr == 12'h305) ||
              (req_csr_addr == 12'h341) || (req_csr_addr == 12'h342);
`else
    addr_ok = 1'b1;
`endif
  end

  // State register and captured request/result fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      use_imm_q   <= 1'b0;
      zimm_q      <= '0;
      src_zero_q  <= 1'b0;
      rs1_q       <= '0;
      addr_q      <= '0;
      pc_q        <= '0;
      rd_data_q   <= '0;
      new_q       <= '0;
      redir_q     <= '0;
      redir_vld_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      use_imm_q   <= use_imm_d;
      zimm_q      <= zimm_d;
      src_zero_q  <= src_zero_d;
      rs1_q       <= rs1_d;
      addr_q      <= addr_d;
      pc_q        <= pc_d;
      rd_data_q   <= rd_data_d;
      new_q       <= new_d;
      redir_q     <= redir_d;
      redir_vld_q <= redir_vld_d;
      illegal_q   <= illegal_d;
    end
  end

  // Next-state logic and capture of request, old CSR value and redirect target.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    use_imm_d   = use_imm_q;
    zimm_d      = zimm_q;
    src_zero_d  = src_zero_q;
    rs1_d       = rs1_q;
    addr_d      = addr_q;
    pc_d        = pc_q;
    rd_data_d   = rd_data_q;
    new_d       = new_q;
    redir_d     = redir_q;
    redir_vld_d = redir_vld_q;
    illegal_d   = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d        = req_op;
          use_imm_d   = req_use_imm;
          zimm_d      = req_zimm;
          src_zero_d  = req_src_zero;
          rs1_d       = req_rs1_data;
          addr_d      = req_csr_addr;
          pc_d        = req_pc;
          rd_data_d   = '0;
          new_d       = '0;
          redir_d     = '0;
          redir_vld_d = 1'b0;
          illegal_d   = 1'b0;
          case (req_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
              if (addr_ok) begin
                state_d = S_RD;
              end else begin
                state_d     = S_TRAP;
                illegal_d   = 1'b1;
                redir_vld_d = 1'b1;
              end
            end
            OP_ECALL: begin
              state_d     = S_TRAP;
              redir_vld_d = 1'b1;
            end
            OP_MRET: begin
              state_d     = S_RET;
              redir_vld_d = 1'b1;
            end
            default: begin
`ifdef CSR_TRAP_ILLEGAL_EN
              state_d     = S_TRAP;
              illegal_d   = 1'b1;
              redir_vld_d = 1'b1;
`else
              state_d = S_RESP;
`endif
            end
          endcase
        end
      end
      S_RD: begin
        rd_data_d = read_csr_data;
        case (op_q)
          OP_CSRRS: new_d = read_csr_data | opnd;
          OP_CSRRC: new_d = read_csr_data & ~opnd;
          default:  new_d = opnd;
        endcase
        state_d = S_WR;
      end
      S_WR: state_d = S_RESP;
      S_TRAP: begin
        redir_d = read_csr_data;
        state_d = S_RESP;
      end
      S_RET: begin
        redir_d = read_csr_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobes and response outputs; strobes are forced off while reset is low
  // because the state register still holds the abandoned state in that cycle.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    redirect_valid = 1'b0;
    csr_ctl        = 4'b0000;
    csr_addr       = '0;
    mcause_value   = '0;
    write_csr_data = '0;
    resp_rd_data   = rd_data_q;
    redirect_pc    = redir_q;
    unique case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_RD: begin
        csr_ctl  = 4'b0100;
        csr_addr = addr_q;
      end
      S_WR: begin
        csr_addr       = addr_q;
        write_csr_data = new_q;
        if (op_q == OP_CSRRW || !src_zero_q) csr_ctl = 4'b1000;
      end
      S_TRAP: begin
        csr_ctl        = 4'b0010;
        write_csr_data = pc_q;
        mcause_value   = illegal_q ? XLEN'(2) : ECALL_CAUSE;
      end
      S_RET: csr_ctl = 4'b0001;
      S_RESP: begin
        resp_valid     = 1'b1;
        redirect_valid = redir_vld_q;
      end
      default: ;
    endcase
    if (!rst) begin
      csr_ctl        = 4'b0000;
      mcause_value   = '0;
      write_csr_data = '0;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small behavioural CSR file model.
module tb_csr_trap_ctrl;
  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = '0;
  logic            req_use_imm = 1'b0;
  logic [4:0]      req_zimm = '0;
  logic            req_src_zero = 1'b0;
  logic [XLEN-1:0] req_rs1_data = '0;
  logic [11:0]     req_csr_addr = '0;
  logic [XLEN-1:0] req_pc = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_rd_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [3:0]      csr_ctl;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] mcause_value;
  logic [XLEN-1:0] write_csr_data;
  logic [XLEN-1:0] read_csr_data;

  csr_trap_ctrl #(.XLEN(XLEN), .ECALL_CAUSE(64'd11)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_use_imm(req_use_imm), .req_zimm(req_zimm), .req_src_zero(req_src_zero),
    .req_rs1_data(req_rs1_data), .req_csr_addr(req_csr_addr), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_data(resp_rd_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_ctl(csr_ctl), .csr_addr(csr_addr), .mcause_value(mcause_value),
    .write_csr_data(write_csr_data), .read_csr_data(read_csr_data)
  );

  always #5 clk = ~clk;

  // CSR file model
  logic [XLEN-1:0] m_mstatus = 64'h1800;
  logic [XLEN-1:0] m_mtvec   = 64'h0;
  logic [XLEN-1:0] m_mepc    = 64'h0;
  logic [XLEN-1:0] m_mcause  = 64'h5;
  int wr_cnt   = 0;
  int trap_cnt = 0;

  always @* begin
    read_csr_data = '0;
    if (csr_ctl[2]) begin
      case (csr_addr)
        12'h300: read_csr_data = m_mstatus;
        12'h305: read_csr_data = m_mtvec;
        12'h341: read_csr_data = m_mepc;
        12'h342: read_csr_data = m_mcause;
        default: read_csr_data = '0;
      endcase
    end else if (csr_ctl[1]) begin
      read_csr_data = m_mtvec;
    end else if (csr_ctl[0]) begin
      read_csr_data = m_mepc;
    end
  end

  always @(posedge clk) begin
    if (csr_ctl[3]) begin
      wr_cnt <= wr_cnt + 1;
      case (csr_addr)
        12'h300: m_mstatus <= write_csr_data;
        12'h305: m_mtvec   <= write_csr_data;
        12'h341: m_mepc    <= write_csr_data;
        12'h342: m_mcause  <= write_csr_data;
        default: ;
      endcase
    end
    if (csr_ctl[1]) begin
      trap_cnt <= trap_cnt + 1;
      m_mepc   <= write_csr_data;
      m_mcause <= mcause_value;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single accept edge.
  task automatic issue(input logic [2:0] op, input logic imm, input logic [4:0] zimm,
                       input logic src0, input logic [XLEN-1:0] rs1,
                       input logic [11:0] addr, input logic [XLEN-1:0] pc);
    req_valid    = 1'b1;
    req_op       = op;
    req_use_imm  = imm;
    req_zimm     = zimm;
    req_src_zero = src0;
    req_rs1_data = rs1;
    req_csr_addr = addr;
    req_pc       = pc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  int wr0;
  int tr0;

  initial begin
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_csr_ctl", 64'(csr_ctl), 64'd0);

    // CSRRW mtvec <= 0x80000100
    issue(3'b000, 1'b0, 5'd0, 1'b0, 64'h8000_0100, 12'h305, 64'h0);
    chk("rw_rd_ctl", 64'(csr_ctl), 64'b0100);
    chk("rw_rd_addr", 64'(csr_addr), 64'h305);
    chk("rw_rd_req_ready", 64'(req_ready), 64'd0);
    chk("rw_rd_resp_valid", 64'(resp_valid), 64'd0);
    tick();
    chk("rw_wr_ctl", 64'(csr_ctl), 64'b1000);
    chk("rw_wr_data", write_csr_data, 64'h8000_0100);
    chk("rw_wr_mcause_zero", mcause_value, 64'h0);
    chk("rw_wr_resp_valid", 64'(resp_valid), 64'd0);
    tick();
    chk("rw_resp_valid", 64'(resp_valid), 64'd1);
    chk("rw_resp_rd", resp_rd_data, 64'h0);
    chk("rw_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rw_resp_ctl", 64'(csr_ctl), 64'd0);
    chk("rw_mtvec_model", m_mtvec, 64'h8000_0100);
    handshake();
    chk("rw_idle_ready", 64'(req_ready), 64'd1);
    chk("rw_idle_resp_valid", 64'(resp_valid), 64'd0);

    // CSRRS mstatus |= 0x8
    issue(3'b001, 1'b0, 5'd0, 1'b0, 64'h8, 12'h300, 64'h0);
    tick();
    chk("rs_wr_ctl", 64'(csr_ctl), 64'b1000);
    chk("rs_wr_data", write_csr_data, 64'h1808);
    tick();
    chk("rs_resp_rd", resp_rd_data, 64'h1800);
    handshake();

    // CSRRSI mstatus |= 3 (immediate form ignores rs1)
    issue(3'b001, 1'b1, 5'd3, 1'b0, 64'hFFFF_0000, 12'h300, 64'h0);
    tick();
    chk("rsi_wr_data", write_csr_data, 64'h180B);
    tick();
    chk("rsi_resp_rd", resp_rd_data, 64'h1808);
    handshake();

    // CSRRC mcause with src_zero: write suppressed
    wr0 = wr_cnt;
    issue(3'b010, 1'b0, 5'd0, 1'b1, 64'h0, 12'h342, 64'h0);
    chk("rc0_rd_ctl", 64'(csr_ctl), 64'b0100);
    tick();
    chk("rc0_wr_ctl", 64'(csr_ctl), 64'd0);
    tick();
    chk("rc0_resp_rd", resp_rd_data, 64'h5);
    chk("rc0_no_write", 64'(wr_cnt - wr0), 64'd0);
    chk("rc0_mcause_model", m_mcause, 64'h5);
    handshake();

    // ECALL
    issue(3'b011, 1'b0, 5'd0, 1'b0, 64'h0, 12'h0, 64'h8000_0040);
    chk("ec_ctl", 64'(csr_ctl), 64'b0010);
    chk("ec_wdata", write_csr_data, 64'h8000_0040);
    chk("ec_mcause", mcause_value, 64'd11);
    tick();
    chk("ec_resp_valid", 64'(resp_valid), 64'd1);
    chk("ec_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("ec_redirect_pc", redirect_pc, 64'h8000_0100);
    chk("ec_resp_rd", resp_rd_data, 64'h0);
    chk("ec_resp_mcause_zero", mcause_value, 64'h0);
    chk("ec_mepc_model", m_mepc, 64'h8000_0040);
    handshake();

    // MRET
    issue(3'b100, 1'b0, 5'd0, 1'b0, 64'h0, 12'h0, 64'h0);
    chk("mr_ctl", 64'(csr_ctl), 64'b0001);
    tick();
    chk("mr_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("mr_redirect_pc", redirect_pc, 64'h8000_0040);
    handshake();

    // Undefined op: silent no-op, one-cycle to response
    wr0 = wr_cnt;
    tr0 = trap_cnt;
    issue(3'b111, 1'b0, 5'd0, 1'b0, 64'h1, 12'h300, 64'h0);
    chk("ud_resp_valid", 64'(resp_valid), 64'd1);
    chk("ud_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("ud_resp_rd", resp_rd_data, 64'h0);
    chk("ud_no_strobes", 64'((wr_cnt - wr0) + (trap_cnt - tr0)), 64'd0);
    handshake();

    // ECALL with delayed consumer
    tr0 = trap_cnt;
    issue(3'b011, 1'b0, 5'd0, 1'b0, 64'h0, 12'h0, 64'h8000_0080);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("st_resp_valid", 64'(resp_valid), 64'd1);
      chk("st_redirect_pc", redirect_pc, 64'h8000_0100);
      chk("st_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    chk("st_one_trap", 64'(trap_cnt - tr0), 64'd1);
    handshake();
    chk("st_idle_ready", 64'(req_ready), 64'd1);

    // Reset during WR of CSRRW
    wr0 = wr_cnt;
    issue(3'b000, 1'b0, 5'd0, 1'b0, 64'h1234, 12'h341, 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rw_rst_ctl", 64'(csr_ctl), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rw_rst_ready", 64'(req_ready), 64'd1);
    chk("rw_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rw_rst_no_write", 64'(wr_cnt - wr0), 64'd0);
    chk("rw_rst_mepc", m_mepc, 64'h8000_0080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
